// File: rtl/sync_debounce.sv
// Purpose : multi-channel input conditioner. Each channel has an N-flop synchronizer and a per-channel debounce counter.
// Latency : SYNC_STAGES edges to sync_output, plus DEBOUNCE_CYCLES edges to debounced and the rise/fall pulses.
// Backpressure: none; free-running. Every input sample is consumed on every clk edge.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous, active-low reset
//   async_input  raw asynchronous channel inputs
//   sync_output  last synchronizer stage (not debounced)
//   debounced    registered debounced level per channel
//   rise_pulse   one-cycle pulse when a debounced bit goes 0->1
//   fall_pulse   one-cycle pulse when a debounced bit goes 1->0
//   any_change   OR of all rise/fall pulses, aligned with them
//   stable       high when no channel has a pending or counting difference
module sync_debounce #(
    parameter int                  NUM_BITS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [NUM_BITS-1:0] RESET_VALUE     = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] async_input,
    output logic [NUM_BITS-1:0] sync_output,
    output logic [NUM_BITS-1:0] debounced,
    output logic [NUM_BITS-1:0] rise_pulse,
    output logic [NUM_BITS-1:0] fall_pulse,
    output logic                any_change,
    output logic                stable
);

    // The counter only has to hold 0..DEBOUNCE_CYCLES-1. It is kept at least one bit wide.
    localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BITS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_BITS-1:0] r_deb;
    logic [NUM_BITS-1:0] r_rise;
    logic [NUM_BITS-1:0] r_fall;
    logic                r_any;
    logic [CW-1:0]       r_cnt [NUM_BITS];

    logic [NUM_BITS-1:0] w_sync_last;
    logic [NUM_BITS-1:0] w_diff;
    logic [NUM_BITS-1:0] w_flip;
    logic [CW-1:0]       w_cnt_nxt [NUM_BITS];
    logic                w_cnt_zero;

    // Synchronizer chain. Pure flop-to-flop, so metastability has whole cycles to resolve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= async_input;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_diff      = w_sync_last ^ r_deb;

    // A channel flips only when it has already counted DEBOUNCE_CYCLES-1 differing
    // cycles and still differs. Any agreement clears the count, so a bounce restarts it.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_diff[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_flip[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb  <= RESET_VALUE;
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
            for (int i = 0; i < NUM_BITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb  <= r_deb ^ w_flip;
            // The pulses come from the same flip that updates r_deb, so they line up with the new level.
            r_rise <= w_flip & w_sync_last;
            r_fall <= w_flip & ~w_sync_last;
            r_any  <= |w_flip;
            for (int i = 0; i < NUM_BITS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        w_cnt_zero = 1'b1;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (r_cnt[i] != '0) begin
                w_cnt_zero = 1'b0;
            end
        end
    end

    assign sync_output = w_sync_last;
    assign debounced   = r_deb;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign any_change  = r_any;
    assign stable      = w_cnt_zero && (w_sync_last == r_deb);

endmodule

// File: tb/tb_sync_debounce.sv
// Purpose : directed bench for sync_debounce (default parameters plus a 1-bit/3-stage/1-cycle instance).
// Latency : inputs are driven 1 time unit after a rising edge and are checked after the following edge.
// Backpressure: not applicable.
module tb_sync_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] async_input;
    logic [3:0] sync_output, debounced, rise_pulse, fall_pulse;
    logic       any_change, stable;

    logic [0:0] p_in, p_sync, p_deb, p_rise, p_fall;
    logic       p_any, p_stable;

    int errors = 0;
    int checks = 0;

    sync_debounce u_dut (
        .clk         (clk),
        .reset       (reset),
        .async_input (async_input),
        .sync_output (sync_output),
        .debounced   (debounced),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .any_change  (any_change),
        .stable      (stable)
    );

    sync_debounce #(
        .NUM_BITS        (1),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .RESET_VALUE     (1'b0)
    ) u_par (
        .clk         (clk),
        .reset       (reset),
        .async_input (p_in),
        .sync_output (p_sync),
        .debounced   (p_deb),
        .rise_pulse  (p_rise),
        .fall_pulse  (p_fall),
        .any_change  (p_any),
        .stable      (p_stable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] in;
        logic [3:0] e_sync;
        logic [3:0] e_deb;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
        logic       e_any;
        logic       e_stable;
    } vec_t;

    vec_t vecs [21];

    initial begin
        logic [6:0] bseq;
        logic       b;
        int         rises;

        // Edges are counted from reset release. Row k holds the input driven before edge k+1
        // and the outputs expected after that edge.
        //            in     sync   deb    rise   fall   any  stable
        vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[1]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[2]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[3]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[4]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[5]  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1};
        vecs[6]  = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[7]  = '{4'hA, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[8]  = '{4'hA, 4'hA, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{4'hA, 4'hA, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[10] = '{4'hA, 4'hA, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[11] = '{4'hA, 4'hA, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[12] = '{4'hA, 4'hA, 4'hA, 4'h0, 4'h5, 1'b1, 1'b1};
        vecs[13] = '{4'hA, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[14] = '{4'h5, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[15] = '{4'h5, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[16] = '{4'h5, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[17] = '{4'h5, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[18] = '{4'h5, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[19] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'hA, 1'b1, 1'b1};
        vecs[20] = '{4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0, 1'b1};

        // Reset state: hold reset low with every input high.
        reset       = 1'b1;
        async_input = 4'hF;
        p_in        = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst sync",   32'(sync_output), 32'h0);
        chk("rst deb",    32'(debounced),   32'h0);
        chk("rst rise",   32'(rise_pulse),  32'h0);
        chk("rst fall",   32'(fall_pulse),  32'h0);
        chk("rst any",    32'(any_change),  32'h0);
        chk("rst stable", 32'(stable),      32'h1);
        #3 reset = 1'b1;

        // Table: rise on all channels, then a fall to 1010, then a simultaneous rise and fall.
        for (int k = 0; k < 21; k++) begin
            async_input = vecs[k].in;
            tick();
            chk($sformatf("v%0d sync", k+1),   32'(sync_output), 32'(vecs[k].e_sync));
            chk($sformatf("v%0d deb", k+1),    32'(debounced),   32'(vecs[k].e_deb));
            chk($sformatf("v%0d rise", k+1),   32'(rise_pulse),  32'(vecs[k].e_rise));
            chk($sformatf("v%0d fall", k+1),   32'(fall_pulse),  32'(vecs[k].e_fall));
            chk($sformatf("v%0d any", k+1),    32'(any_change),  32'(vecs[k].e_any));
            chk($sformatf("v%0d stable", k+1), 32'(stable),      32'(vecs[k].e_stable));
        end

        // Glitch: channel 1 is high for 3 cycles, so it must be rejected.
        for (int k = 1; k <= 8; k++) begin
            async_input = (k <= 3) ? 4'h7 : 4'h5;
            tick();
            chk($sformatf("glitch%0d deb", k),  32'(debounced),  32'h5);
            chk($sformatf("glitch%0d rise", k), 32'(rise_pulse), 32'h0);
            chk($sformatf("glitch%0d fall", k), 32'(fall_pulse), 32'h0);
            if (k == 4) chk("glitch mid stable", 32'(stable), 32'h0);
        end
        chk("glitch end stable", 32'(stable), 32'h1);

        // Reset mid-count: after 2 debounce cycles, assert reset between edges.
        for (int k = 1; k <= 4; k++) begin
            async_input = 4'hE;
            tick();
        end
        chk("pre-rst stable", 32'(stable), 32'h0);
        #3 reset = 1'b0;
        #1;
        chk("midrst sync",   32'(sync_output), 32'h0);
        chk("midrst deb",    32'(debounced),   32'h0);
        chk("midrst rise",   32'(rise_pulse),  32'h0);
        chk("midrst fall",   32'(fall_pulse),  32'h0);
        chk("midrst any",    32'(any_change),  32'h0);
        chk("midrst stable", 32'(stable),      32'h1);
        #1 reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("postrst%0d deb", k),  32'(debounced),  (k >= 6) ? 32'hE : 32'h0);
            chk($sformatf("postrst%0d rise", k), 32'(rise_pulse), (k == 6) ? 32'hE : 32'h0);
            chk($sformatf("postrst%0d fall", k), 32'(fall_pulse), 32'h0);
        end

        // Bounce on channel 0: 1,1,0,1,1,1,1. The rise comes 4 edges after the last restart.
        bseq  = 7'b1111011;   // bit 0 is applied first
        rises = 0;
        for (int k = 1; k <= 12; k++) begin
            b = (k <= 7) ? bseq[k-1] : 1'b1;
            async_input = {3'b111, b};
            tick();
            if (rise_pulse[0]) rises++;
            chk($sformatf("bounce%0d deb0", k),  32'(debounced[0]),  (k >= 9) ? 32'h1 : 32'h0);
            chk($sformatf("bounce%0d rise0", k), 32'(rise_pulse[0]), (k == 9) ? 32'h1 : 32'h0);
            chk($sformatf("bounce%0d fall0", k), 32'(fall_pulse[0]), 32'h0);
        end
        chk("bounce rise count", 32'(rises), 32'h1);

        // Param instance: 3-stage sync, 1-cycle debounce. Step up, then down.
        for (int dir = 1; dir >= 0; dir--) begin
            p_in = dir[0];
            for (int k = 1; k <= 5; k++) begin
                tick();
                chk($sformatf("par%0d_%0d sync", dir, k), 32'(p_sync),
                    (k >= 3) ? 32'(dir) : 32'(1 - dir));
                chk($sformatf("par%0d_%0d deb", dir, k), 32'(p_deb),
                    (k >= 4) ? 32'(dir) : 32'(1 - dir));
                chk($sformatf("par%0d_%0d rise", dir, k), 32'(p_rise),
                    (k == 4 && dir == 1) ? 32'h1 : 32'h0);
                chk($sformatf("par%0d_%0d fall", dir, k), 32'(p_fall),
                    (k == 4 && dir == 0) ? 32'h1 : 32'h0);
                chk($sformatf("par%0d_%0d any", dir, k), 32'(p_any),
                    (k == 4) ? 32'h1 : 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
